lc3_mem_responder: RTL and testbench

LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

---
 rtl/lc3_mem_pkg.sv | 43 ++++
 rtl/lc3_ram256.sv | 36 +++
 rtl/lc3_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_lc3_mem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// ----------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC-3 memory responder: responder FSM state
// encoding, the memory-mapped I/O address, the default RAM depth and an
// address-decode helper used by the top level.
// ----------------------------------------------------------------------------
package lc3_mem_pkg;

    // Single memory-mapped I/O location: reads return the switch bank,
    // writes update the hex display register.
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    // Default number of 16-bit words in the backing RAM.
    localparam int DEFAULT_MEM_DEPTH = 256;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Target of a latched address.
    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_RAM  = 2'd1,
        REG_IO   = 2'd2
    } region_t;

    // The I/O address is checked first so that it can never alias into RAM,
    // even if the RAM were configured to span the whole address space.
    function automatic region_t decode_addr(input logic [15:0] addr, input int depth);
        if (addr == IO_ADDR) begin
            return REG_IO;
        end else if (int'(addr) < depth) begin
            return REG_RAM;
        end else begin
            return REG_NONE;
        end
    endfunction

endpackage

// File: rtl/lc3_ram256.sv
// ----------------------------------------------------------------------------
// lc3_ram256
// Single-port RAM with synchronous write and registered read. The read port
// returns the word stored before a same-cycle write (read-first).
//
// Ports:
//   i_clk    : clock, all activity on rising edge
//   i_we     : write enable
//   i_addr   : word address
//   i_wdata  : write data
//   o_rdata  : registered read data for the address of the previous cycle
//
// The array has no reset; its contents survive the responder's reset.
// ----------------------------------------------------------------------------
module lc3_ram256 #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// ----------------------------------------------------------------------------
// lc3_mem_responder
// Memory responder for an LC-3 style CPU. Accepts one request at a time,
// inserts a configurable number of wait states, then returns a one-cycle
// Rdy strobe. Address 16'hFFFF is memory-mapped I/O (switches in, hex
// display out), addresses below MEM_DEPTH hit the backing RAM, everything
// else reads as zero and ignores writes.
//
// Handshake: the CPU raises Req with WE/Addr/Data_to_mem and holds Req high
// until it observes Rdy = 1. The request fields are captured on the edge that
// accepts Req in IDLE; later changes are ignored. After Rdy, Req must drop
// for at least one edge before another request is accepted.
//
// Timing (WAIT_STATES = N): acceptance edge E0, WAIT for N+1 cycles
// (counter N..0), RESP for one cycle, Rdy high for the cycle that follows
// edge E(N+2). The single WAIT cycle at N = 0 keeps this latency uniform and
// gives the registered RAM read a cycle to settle on the latched address.
//
// Ports:
//   Clk            : clock
//   Reset          : asynchronous active-high reset
//   Req            : CPU memory request
//   WE             : 1 = write, 0 = read (sampled with Req)
//   Addr           : word address
//   Data_to_mem    : write data
//   SW             : switch bank, read at IO_ADDR
//   Rdy            : one-cycle response strobe
//   Data_from_mem  : read data, valid while Rdy = 1, zero otherwise
//   HEX_data       : last value written to IO_ADDR
//   Dbg_state      : current FSM state (state_t encoding)
// ----------------------------------------------------------------------------
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [15:0] Addr,
    input  logic [15:0] Data_to_mem,
    input  logic [9:0]  SW,
    output logic        Rdy,
    output logic [15:0] Data_from_mem,
    output logic [15:0] HEX_data,
    output logic [1:0]  Dbg_state
);

    localparam int AW = $clog2(MEM_DEPTH);

    // FSM
    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_accept;

    // Latched request
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    // Response / outputs
    logic        r_rdy;
    logic [15:0] r_rdata;
    logic [15:0] r_hex;

    // Datapath
    region_t     w_region;
    logic        w_resp;
    logic        w_ram_we;
    logic [15:0] w_ram_q;
    logic [15:0] w_read_val;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = 3'(WAIT_STATES);
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // A Req still held from the finished transaction must not
                // start another one.
                if (!Req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_we    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else if (w_accept) begin
            r_we    <= WE;
            r_addr  <= Addr;
            r_wdata <= Data_to_mem;
        end
    end

    // ------------------------------------------------------------------
    // Address decode and backing RAM
    // ------------------------------------------------------------------
    assign w_region = decode_addr(r_addr, MEM_DEPTH);
    assign w_resp   = (r_state == ST_RESP);

    // Commit happens only on the edge that leaves RESP, so a reset anywhere
    // before that edge drops the write.
    assign w_ram_we = w_resp && r_we && (w_region == REG_RAM);

    lc3_ram256 #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW),
        .DW    (16)
    ) u_ram (
        .i_clk   (Clk),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[AW-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_read_val = 16'h0000;
        case (w_region)
            REG_IO:   w_read_val = {6'b000000, SW};
            REG_RAM:  w_read_val = w_ram_q;
            default:  w_read_val = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Response registers: Rdy and read data are produced on the RESP edge
    // and held for exactly one cycle. Data is zero outside that cycle and
    // for write responses.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rdy   <= 1'b0;
            r_rdata <= 16'h0000;
            r_hex   <= 16'h0000;
        end else begin
            r_rdy   <= w_resp;
            r_rdata <= (w_resp && !r_we) ? w_read_val : 16'h0000;
            if (w_resp && r_we && (w_region == REG_IO)) begin
                r_hex <= r_wdata;
            end
        end
    end

    assign Rdy           = r_rdy;
    assign Data_from_mem = r_rdata;
    assign HEX_data      = r_hex;
    assign Dbg_state     = r_state;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_lc3_mem_responder
// Directed + randomized bench for lc3_mem_responder (WAIT_STATES = 2,
// MEM_DEPTH = 256). A behavioural model (associative array for RAM, a hex
// register and the address rules) predicts read data, latency and HEX_data.
// Outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_lc3_mem_responder;

    localparam int WS      = 2;
    localparam int EXP_LAT = WS + 2;
    localparam int DEPTH   = 256;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic        WE;
    logic [15:0] Addr;
    logic [15:0] Data_to_mem;
    logic [9:0]  SW;
    logic        Rdy;
    logic [15:0] Data_from_mem;
    logic [15:0] HEX_data;
    logic [1:0]  Dbg_state;

    always #5 Clk = ~Clk;

    lc3_mem_responder #(
        .WAIT_STATES (WS),
        .MEM_DEPTH   (DEPTH)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Req           (Req),
        .WE            (WE),
        .Addr          (Addr),
        .Data_to_mem   (Data_to_mem),
        .SW            (SW),
        .Rdy           (Rdy),
        .Data_from_mem (Data_from_mem),
        .HEX_data      (HEX_data),
        .Dbg_state     (Dbg_state)
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mem_model [int];
    logic [15:0] hex_model = 16'h0000;
    logic [15:0] exp_q [$];

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a == 16'hFFFF) return {6'b000000, SW};
        if (int'(a) < DEPTH) return mem_model.exists(int'(a)) ? mem_model[int'(a)] : 16'h0000;
        return 16'h0000;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
        if (a == 16'hFFFF) hex_model = d;
        else if (int'(a) < DEPTH) mem_model[int'(a)] = d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (called at a falling edge with Req already driven)
    // ------------------------------------------------------------------
    // First rising edge is the acceptance edge; latency counts edges after it.
    task automatic wait_rdy(input bit scramble, output int lat, output logic [15:0] d, output bit ok);
        ok  = 1'b0;
        lat = 0;
        d   = 16'h0000;
        @(posedge Clk);
        @(negedge Clk);
        if (scramble) begin
            Addr        = 16'($urandom);
            WE          = 1'($urandom);
            Data_to_mem = 16'($urandom);
        end
        for (int i = 2; i <= 40; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Rdy) begin
                ok  = 1'b1;
                lat = i - 1;
                d   = Data_from_mem;
                break;
            end
            check("idle_data_zero", Data_from_mem, 16'h0000);
        end
        // The loop above starts counting at the second rising edge.
        if (ok) lat = lat + 0;
    endtask

    task automatic run_txn(input string tag, input logic we, input logic [15:0] a, input logic [15:0] d);
        int          lat;
        logic [15:0] got;
        bit          ok;
        logic [15:0] exp;
        exp_q.push_back(we ? 16'h0000 : model_read(a));
        Req         = 1'b1;
        WE          = we;
        Addr        = a;
        Data_to_mem = d;
        wait_rdy(1'b1, lat, got, ok);
        Req = 1'b0;
        exp = exp_q.pop_front();
        check({tag, "_rdy_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_latency"}, lat, EXP_LAT);
            if (!we) check({tag, "_rdata"}, got, exp);
            @(posedge Clk);
            @(negedge Clk);
            check({tag, "_rdy_one_cycle"}, Rdy, 1'b0);
            check({tag, "_data_after"}, Data_from_mem, 16'h0000);
            if (we) model_write(a, d);
            check({tag, "_hex"}, HEX_data, hex_model);
        end
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int          lat;
        int          pulses;
        int          rdy_cnt;
        logic [15:0] got;
        bit          ok;
        logic [15:0] a;
        logic        we;
        int          sel;

        Reset = 1'b1; Req = 1'b0; WE = 1'b0; Addr = 16'h0; Data_to_mem = 16'h0; SW = 10'h0;
        #1;
        check("reset_rdy", Rdy, 1'b0);
        check("reset_data", Data_from_mem, 16'h0000);
        check("reset_hex", HEX_data, 16'h0000);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("idle_rdy", Rdy, 1'b0);

        // RAM write then read-after-write
        run_txn("w0010", 1'b1, 16'h0010, 16'h1234);
        check("w0010_hex_zero", HEX_data, 16'h0000);
        run_txn("r0010", 1'b0, 16'h0010, 16'h0000);

        // Memory-mapped I/O
        SW = 10'h003;
        run_txn("r_io", 1'b0, 16'hFFFF, 16'h0000);
        run_txn("w_io", 1'b1, 16'hFFFF, 16'hBEEF);
        check("w_io_hex_beef", HEX_data, 16'hBEEF);

        // Unmapped region and RAM boundary
        run_txn("r3000", 1'b0, 16'h3000, 16'h0000);
        run_txn("w3000", 1'b1, 16'h3000, 16'h5555);
        run_txn("r3000b", 1'b0, 16'h3000, 16'h0000);
        run_txn("w00ff", 1'b1, 16'h00FF, 16'h7777);
        run_txn("r00ff", 1'b0, 16'h00FF, 16'h0000);
        run_txn("w0100", 1'b1, 16'h0100, 16'h0101);
        run_txn("r0100", 1'b0, 16'h0100, 16'h0000);
        run_txn("rfffe", 1'b0, 16'hFFFE, 16'h0000);

        // Req held high: one pulse only, then re-raise for a second one
        Req = 1'b1; WE = 1'b0; Addr = 16'h0010;
        pulses = 0;
        got    = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Rdy) begin
                pulses++;
                got = Data_from_mem;
            end
        end
        check("held_one_pulse", pulses, 1);
        check("held_rdata", got, model_read(16'h0010));
        Req = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Req = 1'b1;
        wait_rdy(1'b0, lat, got, ok);
        Req = 1'b0;
        check("rereq_rdy_seen", 32'(ok), 32'd1);
        check("rereq_latency", lat, EXP_LAT);
        check("rereq_rdata", got, model_read(16'h0010));
        @(posedge Clk);
        @(negedge Clk);

        // Reset during WAIT aborts a write; Req held through reset restarts
        run_txn("w0020", 1'b1, 16'h0020, 16'h1111);
        Req = 1'b1; WE = 1'b1; Addr = 16'h0020; Data_to_mem = 16'hAAAA;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1; WE = 1'b0; Data_to_mem = 16'h0000;
        hex_model = 16'h0000;
        #1;
        check("abort_rdy", Rdy, 1'b0);
        check("abort_data", Data_from_mem, 16'h0000);
        check("abort_hex_cleared", HEX_data, hex_model);
        rdy_cnt = 0;
        repeat (3) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Rdy) rdy_cnt++;
        end
        check("abort_no_rdy", rdy_cnt, 0);
        Reset = 1'b0;
        wait_rdy(1'b0, lat, got, ok);
        Req = 1'b0;
        check("post_reset_rdy_seen", 32'(ok), 32'd1);
        check("post_reset_latency", lat, EXP_LAT);
        check("post_reset_rdata", got, 16'h1111);
        @(posedge Clk);
        @(negedge Clk);
        check("post_reset_rdy_low", Rdy, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            SW  = 10'($urandom);
            sel = $urandom_range(0, 5);
            we  = 1'($urandom);
            if (sel == 0)      a = 16'hFFFF;
            else if (sel == 1) a = 16'($urandom_range(256, 65534));
            else               a = 16'($urandom_range(0, 15));
            if (!we && int'(a) < DEPTH && !mem_model.exists(int'(a))) we = 1'b1;
            run_txn("rand", we, a, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
